// File: rtl/mdio_phy_responder_if.sv
// mdio_if: MDIO management bus between the station controller and a PHY
interface mdio_if;
    logic mdc;
    logic mdio_i;
    logic mdio_o;
    logic mdio_oe;
    modport master (output mdc, output mdio_i, input mdio_o, input mdio_oe);
    modport slave (input mdc, input mdio_i, output mdio_o, output mdio_oe);
endinterface

// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder: Clause-22 MDIO PHY-side responder serving a 32x16 register file
module mdio_phy_responder #(
    parameter logic [4:0] PHY_ADDR = 5'h01,
    parameter int PREAMBLE_MIN = 32
) (
    input  logic       clk,
    input  logic       rst,
    mdio_if.slave      mdio,
    input  logic       link_up,
    input  logic [1:0] speed,
    output logic       soft_rst_pulse
);
    typedef enum logic [2:0] {HUNT, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA} state_t;
    localparam logic [5:0] PMIN = 6'(PREAMBLE_MIN);
    state_t state, state_n;
    logic [1:0] mdc_s, mdio_s;
    logic mdc_d, rise, b, rd, hit, wr_pend, srst;
    logic [5:0] pcnt, pcnt_n;
    logic [4:0] bcnt, bcnt_n, regad;
    logic [15:0] sh, rdval;
    logic [15:0] regs [32];
    assign rise = mdc_s[1] & ~mdc_d;
    assign b = mdio_s[1];
    assign rdval = regad == 5'h19 ? {link_up, 4'b0, speed, 1'b0, 5'b0, link_up, 2'b0} : regs[regad];
    assign srst = wr_pend && regad == 5'd0 && sh[15];
    // bring MDC/MDIO into the clk domain and keep a delayed MDC for edge detection
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            mdc_s <= '0;
            mdio_s <= '1;
            mdc_d <= 1'b0;
        end else begin
            mdc_s <= {mdc_s[0], mdio.mdc};
            mdio_s <= {mdio_s[0], mdio.mdio_i};
            mdc_d <= mdc_s[1];
        end
    // frame state, preamble count and bit counter registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= HUNT;
            pcnt <= '0;
            bcnt <= '0;
        end else begin
            state <= state_n;
            pcnt <= pcnt_n;
            bcnt <= bcnt_n;
        end
    // frame sequencing: advance one field per sampled MDC rising edge
    always_comb begin
        state_n = state;
        pcnt_n = pcnt;
        bcnt_n = rise ? bcnt + 5'd1 : bcnt;
        if (rise)
            case (state)
                HUNT: begin
                    bcnt_n = '0;
                    pcnt_n = b ? (pcnt == 6'd63 ? pcnt : pcnt + 6'd1) : 6'd0;
                    if (!b && pcnt >= PMIN) state_n = ST;
                end
                ST: begin
                    bcnt_n = '0;
                    state_n = b ? OP : HUNT;
                end
                OP: if (bcnt == 5'd1) begin
                    bcnt_n = '0;
                    state_n = (sh[0] ^ b) ? PHYAD : HUNT;
                end
                PHYAD: if (bcnt == 5'd4) begin
                    bcnt_n = '0;
                    state_n = REGAD;
                end
                REGAD: if (bcnt == 5'd4) begin
                    bcnt_n = '0;
                    state_n = TA;
                end
                TA: if (bcnt == 5'd1) begin
                    bcnt_n = '0;
                    state_n = rd ? RDATA : WDATA;
                end
                default: if (bcnt == 5'd15) begin
                    bcnt_n = '0;
                    state_n = HUNT;
                end
            endcase
    end
    // field capture, read word latch at TA and serial drive of the read data
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sh <= '0;
            regad <= '0;
            rd <= 1'b0;
            hit <= 1'b0;
            wr_pend <= 1'b0;
            mdio.mdio_o <= 1'b1;
            mdio.mdio_oe <= 1'b0;
        end else begin
            wr_pend <= 1'b0;
            if (rise)
                case (state)
                    OP: begin
                        sh <= {sh[14:0], b};
                        if (bcnt == 5'd1) rd <= sh[0];
                    end
                    PHYAD: begin
                        sh <= {sh[14:0], b};
                        if (bcnt == 5'd4) hit <= {sh[3:0], b} == PHY_ADDR;
                    end
                    REGAD: begin
                        sh <= {sh[14:0], b};
                        if (bcnt == 5'd4) regad <= {sh[3:0], b};
                    end
                    TA: if (bcnt == 5'd0) begin
                        sh <= rdval;
                        if (rd && hit) begin
                            mdio.mdio_oe <= 1'b1;
                            mdio.mdio_o <= 1'b0;
                        end
                    end else if (rd && hit) begin
                        mdio.mdio_o <= sh[15];
                        sh <= {sh[14:0], 1'b0};
                    end
                    WDATA: begin
                        sh <= {sh[14:0], b};
                        if (bcnt == 5'd15) wr_pend <= hit;
                    end
                    RDATA: if (bcnt == 5'd15) begin
                        mdio.mdio_oe <= 1'b0;
                        mdio.mdio_o <= 1'b1;
                    end else if (hit) begin
                        mdio.mdio_o <= sh[15];
                        sh <= {sh[14:0], 1'b0};
                    end
                    default: ;
                endcase
        end
    // register file commit; a soft reset restores every register and self-clears bit 15
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 16'h1140 : 16'h0000;
            soft_rst_pulse <= 1'b0;
        end else begin
            soft_rst_pulse <= srst;
            if (srst)
                for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 16'h1140 : 16'h0000;
            else if (wr_pend && regad != 5'h19)
                regs[regad] <= sh;
        end
endmodule

// File: tb/tb_mdio_phy_responder.sv
// tb_mdio_phy_responder: vector table, framing corner cases and randomized frames vs a register model
module tb_mdio_phy_responder;
    typedef struct {
        logic wr;
        logic [4:0] pa, ra;
        logic [15:0] wd;
        logic lu;
        logic [1:0] sp;
        logic [15:0] expd;
        logic drv;
        int pulse;
    } vec_t;
    logic clk = 0, rst = 1, link_up = 0, soft_rst_pulse;
    logic [1:0] speed = 2'b01;
    int tests = 0, fails = 0, pulses = 0;
    logic [15:0] m [32];
    logic [15:0] rdat;
    logic ta_ok, rel_ok, drv, so, soe;
    vec_t tv [11];
    mdio_if bus();
    mdio_phy_responder #(.PHY_ADDR(5'h01), .PREAMBLE_MIN(32)) dut (
        .clk(clk),
        .rst(rst),
        .mdio(bus),
        .link_up(link_up),
        .speed(speed),
        .soft_rst_pulse(soft_rst_pulse)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (soft_rst_pulse) pulses++;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask
    function automatic void mreset();
        for (int i = 0; i < 32; i++) m[i] = 16'h0000;
        m[0] = 16'h1140;
    endfunction
    function automatic logic [15:0] mread(input logic [4:0] ra);
        if (ra == 5'h19) return (16'(link_up) << 15) | (16'(speed) << 9) | (16'(link_up) << 2);
        return m[ra];
    endfunction
    function automatic int mwrite(input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd);
        if (pa != 5'h01) return 0;
        if (ra == 5'd0 && wd[15]) begin
            mreset();
            return 1;
        end
        if (ra != 5'h19) m[ra] = wd;
        return 0;
    endfunction
    task automatic mbit(input logic b, output logic o, output logic oe);
        bus.mdio_i = b;
        bus.mdc = 1'b0;
        repeat (4) @(negedge clk);
        bus.mdc = 1'b1;
        repeat (4) @(negedge clk);
        o = bus.mdio_o;
        oe = bus.mdio_oe;
    endtask
    task automatic hdr(input int pre, input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra);
        logic o, oe;
        logic [13:0] h;
        h = {2'b01, op, pa, ra};
        for (int i = 0; i < pre; i++) mbit(1'b1, o, oe);
        for (int i = 13; i >= 0; i--) mbit(h[i], o, oe);
    endtask
    task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd, output logic [15:0] rd, output logic ta, output logic rel,
                         output logic dv);
        logic o, oe;
        hdr(pre, op, pa, ra);
        rd = '0;
        mbit(1'b1, o, oe);
        ta = oe && !o;
        dv = oe;
        mbit(op == 2'b10, o, oe);
        rd[15] = o;
        dv |= oe;
        for (int i = 14; i >= 0; i--) begin
            mbit(op == 2'b10 ? 1'b1 : wd[i + 1], o, oe);
            rd[i] = o;
            dv |= oe;
        end
        mbit(op == 2'b10 ? 1'b1 : wd[0], o, oe);
        rel = !oe && o;
        dv |= oe;
        repeat (6) @(negedge clk);
    endtask
    task automatic read_chk(input string name, input logic [4:0] ra);
        frame(32, 2'b10, 5'h01, ra, 16'h0, rdat, ta_ok, rel_ok, drv);
        chk({name, " data"}, rdat, mread(ra));
        chk({name, " ta"}, ta_ok, 1'b1);
        chk({name, " release"}, rel_ok, 1'b1);
    endtask
    initial begin
        logic wr;
        logic [4:0] pa, ra;
        logic [15:0] wd;
        int ep;
        bus.mdc = 1'b0;
        bus.mdio_i = 1'b1;
        mreset();
        tv[0]  = '{1'b0, 5'h01, 5'h00, 16'h0000, 1'b0, 2'b01, 16'h1140, 1'b1, 0};
        tv[1]  = '{1'b1, 5'h01, 5'h04, 16'h01E1, 1'b0, 2'b01, 16'h0000, 1'b0, 0};
        tv[2]  = '{1'b0, 5'h01, 5'h04, 16'h0000, 1'b0, 2'b01, 16'h01E1, 1'b1, 0};
        tv[3]  = '{1'b0, 5'h02, 5'h04, 16'h0000, 1'b0, 2'b01, 16'h0000, 1'b0, 0};
        tv[4]  = '{1'b0, 5'h01, 5'h19, 16'h0000, 1'b1, 2'b10, 16'h8404, 1'b1, 0};
        tv[5]  = '{1'b1, 5'h01, 5'h19, 16'hFFFF, 1'b1, 2'b11, 16'h0000, 1'b0, 0};
        tv[6]  = '{1'b0, 5'h01, 5'h19, 16'h0000, 1'b1, 2'b11, 16'h8604, 1'b1, 0};
        tv[7]  = '{1'b1, 5'h01, 5'h04, 16'hAAAA, 1'b0, 2'b01, 16'h0000, 1'b0, 0};
        tv[8]  = '{1'b1, 5'h01, 5'h00, 16'hB100, 1'b0, 2'b01, 16'h0000, 1'b0, 1};
        tv[9]  = '{1'b0, 5'h01, 5'h00, 16'h0000, 1'b0, 2'b01, 16'h1140, 1'b1, 0};
        tv[10] = '{1'b0, 5'h01, 5'h04, 16'h0000, 1'b0, 2'b01, 16'h0000, 1'b1, 0};
        repeat (3) @(negedge clk);
        chk("reset mdio_o", bus.mdio_o, 1'b1);
        chk("reset mdio_oe", bus.mdio_oe, 1'b0);
        chk("reset soft_rst_pulse", soft_rst_pulse, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            link_up = tv[i].lu;
            speed = tv[i].sp;
            pulses = 0;
            frame(32, tv[i].wr ? 2'b01 : 2'b10, tv[i].pa, tv[i].ra, tv[i].wd, rdat, ta_ok, rel_ok, drv);
            if (tv[i].wr) begin
                void'(mwrite(tv[i].pa, tv[i].ra, tv[i].wd));
                chk($sformatf("vec%0d pulses", i), pulses, tv[i].pulse);
            end else if (tv[i].drv) begin
                chk($sformatf("vec%0d data", i), rdat, tv[i].expd);
                chk($sformatf("vec%0d ta", i), ta_ok, 1'b1);
                chk($sformatf("vec%0d release", i), rel_ok, 1'b1);
            end
            chk($sformatf("vec%0d drive", i), drv, tv[i].drv);
        end
        link_up = 1'b0;
        speed = 2'b01;
        frame(31, 2'b10, 5'h01, 5'h00, 16'h0, rdat, ta_ok, rel_ok, drv);
        chk("short preamble drive", drv, 1'b0);
        read_chk("after short preamble", 5'h00);
        frame(32, 2'b11, 5'h01, 5'h04, 16'h1234, rdat, ta_ok, rel_ok, drv);
        chk("op11 drive", drv, 1'b0);
        read_chk("after op11", 5'h04);
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            pa = ($urandom_range(0, 3) == 0) ? 5'h02 : 5'h01;
            ra = ($urandom_range(0, 4) == 0) ? 5'h19 : 5'($urandom_range(0, 7));
            wd = 16'($urandom);
            if (ra == 5'd0) wd[15] = ($urandom_range(0, 3) == 0);
            link_up = 1'($urandom);
            speed = 2'($urandom);
            pulses = 0;
            frame(32, wr ? 2'b01 : 2'b10, pa, ra, wd, rdat, ta_ok, rel_ok, drv);
            if (wr) begin
                ep = mwrite(pa, ra, wd);
                chk($sformatf("rnd%0d pulses", n), pulses, ep);
                chk($sformatf("rnd%0d write drive", n), drv, 1'b0);
            end else if (pa == 5'h01) begin
                chk($sformatf("rnd%0d data r%0h", n, ra), rdat, mread(ra));
                chk($sformatf("rnd%0d ta", n), ta_ok, 1'b1);
                chk($sformatf("rnd%0d release", n), rel_ok, 1'b1);
            end else
                chk($sformatf("rnd%0d mismatch drive", n), drv, 1'b0);
        end
        frame(32, 2'b01, 5'h01, 5'h04, 16'h5A5A, rdat, ta_ok, rel_ok, drv);
        void'(mwrite(5'h01, 5'h04, 16'h5A5A));
        hdr(32, 2'b10, 5'h01, 5'h04);
        for (int i = 0; i < 10; i++) mbit(1'b1, so, soe);
        chk("pre-reset drive", soe, 1'b1);
        chk("pre-reset bit7", so, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid-frame reset oe", bus.mdio_oe, 1'b0);
        chk("mid-frame reset o", bus.mdio_o, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mreset();
        repeat (3) @(negedge clk);
        read_chk("post-reset r4", 5'h04);
        read_chk("post-reset r0", 5'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
